mmb_burst_splitter: RTL

MMB_BURST_SPLITTER -- requirements
Module: mmb_burst_splitter

---
 rtl/mmb_pkg.sv | 21 ++
 rtl/mmb_burst_splitter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mmb_pkg.sv
// ============================================================================
// mmb_pkg : shared types and helpers for the MMB burst splitter
// Revision: 1.0
// ============================================================================
`default_nettype none

package mmb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_SPLIT = 2'd1,
    ST_WR_BURST = 2'd2
  } state_e;

  function automatic int unsigned min_len(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmb_burst_splitter.sv
// ============================================================================
// mmb_burst_splitter : splits long slave bursts into master bursts of at most
//                      MAXBURST words; reads split by command, writes by beat.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mmb_burst_splitter
  import mmb_pkg::*;
#(
  parameter int unsigned AWIDTH   = 8,
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned SBWIDTH  = 5,
  parameter int unsigned MBWIDTH  = 3,
  parameter int unsigned MAXBURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [AWIDTH-1:0]  s_addr,
  input  logic [SBWIDTH-1:0] s_bcnt,
  input  logic               s_wreq,
  input  logic [DWIDTH-1:0]  s_wdat,
  input  logic               s_rreq,
  output logic [DWIDTH-1:0]  s_rdat,
  output logic               s_rval,
  output logic               s_busy,
  output logic [AWIDTH-1:0]  m_addr,
  output logic [MBWIDTH-1:0] m_bcnt,
  output logic               m_wreq,
  output logic [DWIDTH-1:0]  m_wdat,
  output logic               m_rreq,
  input  logic [DWIDTH-1:0]  m_rdat,
  input  logic               m_rval,
  input  logic               m_busy
);

  state_e             state_q, state_d;
  logic [AWIDTH-1:0]  addr_q,  addr_d;
  logic [SBWIDTH-1:0] rem_q,   rem_d;
  logic [MBWIDTH-1:0] sub_q,   sub_d;

  logic [SBWIDTH-1:0] w_len;
  logic [SBWIDTH-1:0] w_first_len;
  logic [SBWIDTH-1:0] w_rem_len;
  logic               w_wr_acc;
  logic               w_rd_acc;

  always_comb begin
    w_len       = (s_bcnt == '0) ? SBWIDTH'(1) : s_bcnt;
    w_first_len = SBWIDTH'(min_len(32'(w_len), MAXBURST));
    w_rem_len   = SBWIDTH'(min_len(32'(rem_q), MAXBURST));
    w_wr_acc    = s_wreq & ~m_busy;
    w_rd_acc    = s_rreq & ~s_wreq & ~m_busy;
  end

  assign s_rdat = m_rdat;
  assign s_rval = m_rval;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      sub_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      sub_q   <= sub_d;
    end
  end

  // rem_q: words still owed after the current one; sub_q: beats left in the
  // current write sub-burst (zero means the next beat opens a new sub-burst).
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    sub_d   = sub_q;
    case (state_q)
      ST_IDLE: begin
        if (w_wr_acc) begin
          if (w_len > SBWIDTH'(1)) begin
            state_d = ST_WR_BURST;
            rem_d   = w_len - SBWIDTH'(1);
            sub_d   = MBWIDTH'(w_first_len - SBWIDTH'(1));
            addr_d  = s_addr + AWIDTH'(w_first_len);
          end
        end else if (w_rd_acc && (32'(w_len) > MAXBURST)) begin
          state_d = ST_RD_SPLIT;
          rem_d   = w_len - SBWIDTH'(MAXBURST);
          addr_d  = s_addr + AWIDTH'(MAXBURST);
        end
      end
      ST_RD_SPLIT: begin
        if (!m_busy) begin
          if (32'(rem_q) <= MAXBURST) begin
            state_d = ST_IDLE;
            rem_d   = '0;
          end else begin
            rem_d  = rem_q - SBWIDTH'(MAXBURST);
            addr_d = addr_q + AWIDTH'(MAXBURST);
          end
        end
      end
      ST_WR_BURST: begin
        if (w_wr_acc) begin
          rem_d = rem_q - SBWIDTH'(1);
          if (sub_q == '0) begin
            sub_d  = MBWIDTH'(w_rem_len - SBWIDTH'(1));
            addr_d = addr_q + AWIDTH'(w_rem_len);
          end else begin
            sub_d = sub_q - MBWIDTH'(1);
          end
          if (rem_q == SBWIDTH'(1)) begin
            state_d = ST_IDLE;
            rem_d   = '0;
            sub_d   = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset gates the request strobes directly since it is asynchronous.
  always_comb begin
    s_busy = 1'b1;
    m_wreq = 1'b0;
    m_rreq = 1'b0;
    m_addr = addr_q;
    m_bcnt = MBWIDTH'(w_rem_len);
    m_wdat = s_wdat;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          m_addr = s_addr;
          m_bcnt = MBWIDTH'(w_first_len);
          m_wreq = s_wreq;
          m_rreq = s_rreq & ~s_wreq;
          s_busy = m_busy;
        end
        ST_RD_SPLIT: begin
          m_rreq = 1'b1;
          s_busy = 1'b1;
        end
        ST_WR_BURST: begin
          m_wreq = s_wreq;
          s_busy = m_busy;
        end
        default: begin
          s_busy = 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
